// File: rtl/position_updater.sv
// rtl/position_updater.sv - frame-synchronous object position register fed by aggregator words
// Optional per-frame slew limiting is compiled in with POS_SLEW_LIMIT_EN.
module position_updater #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int OBJ_W    = 8,
  parameter int OBJ_H    = 8,
  parameter int STEP_MAX = 4
) (
  input  logic        i_clk,
  input  logic        n_btn_rst,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_frame_start,
  output logic [9:0]  o_pos_x,
  output logic [9:0]  o_pos_y,
  output logic        o_update,
  output logic        o_busy,
  output logic [7:0]  o_drop_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLAMP = 2'd1;
  localparam logic [1:0] ARMED = 2'd2;
  localparam logic [1:0] APPLY = 2'd3;

  localparam logic [15:0] MAX_X = 16'(H_ACTIVE - OBJ_W);
  localparam logic [15:0] MAX_Y = 16'(V_ACTIVE - OBJ_H);
  localparam logic [9:0]  RST_X = 10'((H_ACTIVE - OBJ_W) / 2);
  localparam logic [9:0]  RST_Y = 10'((V_ACTIVE - OBJ_H) / 2);
  localparam logic [9:0]  STEP  = 10'(STEP_MAX);

  logic [1:0]  state_q, state_d;
  logic        valid_q, valid_d;
  logic [15:0] raw_x_q, raw_x_d;
  logic [15:0] raw_y_q, raw_y_d;
  logic [9:0]  tgt_x_q, tgt_x_d;
  logic [9:0]  tgt_y_q, tgt_y_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic        upd_pend_q, upd_pend_d;
  logic [9:0]  out_x_q, out_x_d;
  logic [9:0]  out_y_q, out_y_d;
  logic        update_q, update_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic        capture;
  logic [9:0]  next_x, next_y;

  // Move one axis toward its target by at most STEP.
  function automatic logic [9:0] slew_axis(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return cur + ((diff > STEP) ? STEP : diff);
    end else begin
      diff = cur - tgt;
      return cur - ((diff > STEP) ? STEP : diff);
    end
  endfunction

  assign capture = i_valid & ~valid_q;

`ifdef POS_SLEW_LIMIT_EN
  assign next_x = slew_axis(pos_x_q, tgt_x_q);
  assign next_y = slew_axis(pos_y_q, tgt_y_q);
`else
  assign next_x = tgt_x_q;
  assign next_y = tgt_y_q;
`endif

  always_comb begin
    state_d    = state_q;
    valid_d    = i_valid;
    raw_x_d    = raw_x_q;
    raw_y_d    = raw_y_q;
    tgt_x_d    = tgt_x_q;
    tgt_y_d    = tgt_y_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    upd_pend_d = 1'b0;
    drop_cnt_d = drop_cnt_q;
    // Output stage trails the internal position by one cycle so the pulse and value move together.
    out_x_d    = pos_x_q;
    out_y_d    = pos_y_q;
    update_d   = upd_pend_q;

    if (capture) begin
      raw_x_d = i_data[15:0];
      raw_y_d = i_data[31:16];
    end

    case (state_q)
      IDLE: begin
        if (capture) state_d = CLAMP;
      end
      CLAMP: begin
        tgt_x_d = (raw_x_q > MAX_X) ? MAX_X[9:0] : raw_x_q[9:0];
        tgt_y_d = (raw_y_q > MAX_Y) ? MAX_Y[9:0] : raw_y_q[9:0];
        state_d = ARMED;
      end
      ARMED: begin
        // A new command beats a coincident frame boundary; the pending one is lost.
        if (capture) begin
          state_d = CLAMP;
          if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (i_frame_start) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        pos_x_d    = next_x;
        pos_y_d    = next_y;
        upd_pend_d = (next_x != pos_x_q) || (next_y != pos_y_q);
        if (capture)
          state_d = CLAMP;
        else if ((next_x == tgt_x_q) && (next_y == tgt_y_q))
          state_d = IDLE;
        else
          state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b1;
      raw_x_q    <= 16'd0;
      raw_y_q    <= 16'd0;
      tgt_x_q    <= RST_X;
      tgt_y_q    <= RST_Y;
      pos_x_q    <= RST_X;
      pos_y_q    <= RST_Y;
      upd_pend_q <= 1'b0;
      out_x_q    <= RST_X;
      out_y_q    <= RST_Y;
      update_q   <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      raw_x_q    <= raw_x_d;
      raw_y_q    <= raw_y_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      upd_pend_q <= upd_pend_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      update_q   <= update_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_pos_x    = out_x_q;
  assign o_pos_y    = out_y_q;
  assign o_update   = update_q;
  assign o_busy     = (state_q != IDLE);
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: doc/position_updater.md
# position_updater

Downstream consumer of the UART command aggregator's 32-bit position word (x in bits [15:0], y in bits [31:16]). Captures each new command, clamps it so the drawn object stays inside the active area, and applies it only at a frame boundary so the renderer never sees a mid-frame position change. It drives the object position registers read by the pixel renderer.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- OBJ_W, 8, object width in pixels
- OBJ_H, 8, object height in lines
- STEP_MAX, 4, maximum per-frame move per axis when slew limiting is compiled in
- i_clk  in  1  system clock
- n_btn_rst  in  1  asynchronous, active-low reset
- i_valid  in  1  aggregator word-valid
- i_data  in  32  aggregator word; [15:0] x, [31:16] y, unsigned
- i_frame_start  in  1  one-cycle pulse at start of vertical blanking
- o_pos_x  out  10  applied object x (left edge)
- o_pos_y  out  10  applied object y (top edge)
- o_update  out  1  one-cycle pulse in the cycle o_pos_x/o_pos_y change
- o_busy  out  1  high whenever state is not IDLE
- o_drop_cnt  out  8  saturating count of captured commands overwritten before being applied

## Operation
- Capture: rising edge of i_valid (i_valid high, registered copy low). The registered copy resets to 1, so a valid level already high when reset releases is not captured.
- States: IDLE, CLAMP, ARMED, APPLY.
  - IDLE: capture → CLAMP (i_data latched into raw registers).
  - CLAMP: one cycle. tgt_x = min(raw_x, H_ACTIVE-OBJ_W); tgt_y = min(raw_y, V_ACTIVE-OBJ_H). The compare is 16-bit unsigned and the result is truncated to 10 bits. → ARMED.
  - ARMED: i_frame_start → APPLY. A capture → CLAMP and o_drop_cnt increments (saturates at 255).
  - APPLY: one cycle. Update the positions per Configuration and pulse o_update if either axis changed. → IDLE if position now equals target, else → ARMED. A capture during APPLY → CLAMP after the update; this is not counted as a drop.
- Simultaneous capture and i_frame_start in ARMED: the capture wins, the frame is skipped, and the drop is counted.
- i_frame_start outside ARMED is ignored.
- A target equal to the current position still passes through APPLY; o_update stays low.

## Timing
- Reset values: o_pos_x = (H_ACTIVE-OBJ_W)/2 = 316, o_pos_y = (V_ACTIVE-OBJ_H)/2 = 236, o_update 0, o_busy 0, o_drop_cnt 0, state IDLE, target = reset position.
- Reset is asynchronous; assertion mid-operation discards any pending target immediately.
- Capture sampled at edge N → CLAMP during N+1 → ARMED from N+2. The earliest honoured i_frame_start is the one sampled at edge N+2.
- i_frame_start sampled at edge M in ARMED → APPLY during M+1. New o_pos_x/o_pos_y and o_update appear after edge M+2.
- Back-to-back valid pulses are legal. Each rising edge is a capture.

## Configuration
- POS_SLEW_LIMIT_EN defined: in APPLY, each axis moves toward its target by min(|target-current|, STEP_MAX). Large moves span multiple frames, re-arming each frame. A new capture retargets mid-slew from the current position.
- Not defined: APPLY copies target to position in one step, so every honoured frame completes the move and returns to IDLE.

## Test plan
- Reset release with i_valid held high: no capture. Outputs are 316/236, o_busy 0.
- Valid pulse with 0x00C8_0064 (x=100, y=200), then frame_start: o_pos_x=100, o_pos_y=200, o_update one cycle, exactly 2 cycles after frame_start is sampled.
- Data 0x0FFF_FFFF: position clamped to 632/472.
- Two captures before any frame_start (x=10, then x=20): o_drop_cnt=1, only x=20 is applied. A capture coincident with frame_start in ARMED: frame skipped, o_drop_cnt increments.
- With POS_SLEW_LIMIT_EN, STEP_MAX=4, target x=326 from 316: x reads 320, 324, 326 over three frame_starts, with o_busy low after the third. Without the macro, x reads 326 after the first frame_start.
- Assert reset while ARMED with target 100/200: position returns to 316/236 and a later frame_start causes no o_update.
